// File: rtl/ni_rx_dispatch_if.sv
// rtl/ni_rx_dispatch_if.sv - flit ingress and memory/logic payload channels of ni_rx_dispatch
interface ni_rx_dispatch_if;
  logic        Valid_i;
  logic [31:0] Data_i;
  logic        Ready_o;
  logic        MemValid_o;
  logic [23:0] MemData_o;
  logic [3:0]  MemSrc_o;
  logic        MemReady_i;
  logic        LogicValid_o;
  logic [23:0] LogicData_o;
  logic [3:0]  LogicSrc_o;
  logic        LogicReady_i;

  modport slave (
    input  Valid_i, Data_i, MemReady_i, LogicReady_i,
    output Ready_o, MemValid_o, MemData_o, MemSrc_o,
           LogicValid_o, LogicData_o, LogicSrc_o
  );

  modport master (
    output Valid_i, Data_i, MemReady_i, LogicReady_i,
    input  Ready_o, MemValid_o, MemData_o, MemSrc_o,
           LogicValid_o, LogicData_o, LogicSrc_o
  );
endinterface

// File: rtl/ni_rx_dispatch.sv
// rtl/ni_rx_dispatch.sv - 2-entry skid FIFO, parity/seq check, class dispatch; RX_STATS_EN adds delivery counters
module ni_rx_dispatch #(
  parameter int NumSrc      = 16,
  parameter int ErrCntWidth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ni_rx_dispatch_if.slave        bus,
  output logic                   SeqErr_o,
  output logic                   ParErr_o,
  output logic [ErrCntWidth-1:0] ErrCnt_o,
  output logic [15:0]            MemPktCnt_o,
  output logic [15:0]            LogicPktCnt_o
);

  logic [31:0]            r_fifo [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   r_ready;
  logic [1:0]             r_exp_seq [NumSrc];
  logic                   r_mem_valid;
  logic [23:0]            r_mem_data;
  logic [3:0]             r_mem_src;
  logic                   r_logic_valid;
  logic [23:0]            r_logic_data;
  logic [3:0]             r_logic_src;
  logic                   r_seq_err;
  logic                   r_par_err;
  logic [ErrCntWidth-1:0] r_err_cnt;

  logic [31:0] w_head;
  logic [3:0]  w_src;
  logic [1:0]  w_seq;
  logic        w_push, w_nonempty, w_par_bad, w_cls;
  logic        w_mem_take, w_logic_take, w_mem_free, w_logic_free;
  logic        w_drop, w_load_mem, w_load_logic, w_pop, w_seq_bad;
  logic [1:0]  w_count_nxt;

  // Only the head entry is considered; a blocked channel stalls everything behind it.
  always_comb begin
    w_push       = bus.Valid_i & r_ready;
    w_head       = r_fifo[r_rd_ptr];
    w_src        = w_head[31:28];
    w_cls        = w_head[27];
    w_seq        = w_head[26:25];
    w_nonempty   = (r_count != 2'd0);
    w_par_bad    = ^w_head;
    w_mem_take   = r_mem_valid & bus.MemReady_i;
    w_logic_take = r_logic_valid & bus.LogicReady_i;
    w_mem_free   = ~r_mem_valid | w_mem_take;
    w_logic_free = ~r_logic_valid | w_logic_take;
    w_drop       = w_nonempty & w_par_bad;
    w_load_mem   = w_nonempty & ~w_par_bad & w_cls & w_mem_free;
    w_load_logic = w_nonempty & ~w_par_bad & ~w_cls & w_logic_free;
    w_pop        = w_drop | w_load_mem | w_load_logic;
    w_seq_bad    = (w_load_mem | w_load_logic) & (w_seq != r_exp_seq[w_src]);
    w_count_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.Data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_ready       <= 1'b0;
      for (int i = 0; i < NumSrc; i++) begin
        r_exp_seq[i] <= 2'd0;
      end
      r_mem_valid   <= 1'b0;
      r_mem_data    <= 24'd0;
      r_mem_src     <= 4'd0;
      r_logic_valid <= 1'b0;
      r_logic_data  <= 24'd0;
      r_logic_src   <= 4'd0;
      r_seq_err     <= 1'b0;
      r_par_err     <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr ^ w_push;
      r_rd_ptr  <= r_rd_ptr ^ w_pop;
      r_count   <= w_count_nxt;
      r_ready   <= (w_count_nxt < 2'd2);
      if (w_load_mem | w_load_logic) begin
        r_exp_seq[w_src] <= w_seq + 2'd1;
      end
      if (w_load_mem) begin
        r_mem_valid <= 1'b1;
        r_mem_data  <= w_head[23:0];
        r_mem_src   <= w_src;
      end else if (w_mem_take) begin
        r_mem_valid <= 1'b0;
      end
      if (w_load_logic) begin
        r_logic_valid <= 1'b1;
        r_logic_data  <= w_head[23:0];
        r_logic_src   <= w_src;
      end else if (w_logic_take) begin
        r_logic_valid <= 1'b0;
      end
      r_seq_err <= w_seq_bad;
      r_par_err <= w_drop;
      if ((w_seq_bad | w_drop) && (r_err_cnt != {ErrCntWidth{1'b1}})) begin
        r_err_cnt <= r_err_cnt + {{(ErrCntWidth-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef RX_STATS_EN
  logic [15:0] r_mem_pkt_cnt;
  logic [15:0] r_logic_pkt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_pkt_cnt   <= 16'd0;
      r_logic_pkt_cnt <= 16'd0;
    end else begin
      if (w_mem_take)   r_mem_pkt_cnt   <= r_mem_pkt_cnt + 16'd1;
      if (w_logic_take) r_logic_pkt_cnt <= r_logic_pkt_cnt + 16'd1;
    end
  end

  assign MemPktCnt_o   = r_mem_pkt_cnt;
  assign LogicPktCnt_o = r_logic_pkt_cnt;
`else
  assign MemPktCnt_o   = 16'd0;
  assign LogicPktCnt_o = 16'd0;
`endif

  assign bus.Ready_o      = r_ready;
  assign bus.MemValid_o   = r_mem_valid;
  assign bus.MemData_o    = r_mem_data;
  assign bus.MemSrc_o     = r_mem_src;
  assign bus.LogicValid_o = r_logic_valid;
  assign bus.LogicData_o  = r_logic_data;
  assign bus.LogicSrc_o   = r_logic_src;
  assign SeqErr_o         = r_seq_err;
  assign ParErr_o         = r_par_err;
  assign ErrCnt_o         = r_err_cnt;

endmodule

// File: tb/tb_ni_rx_dispatch.sv
// tb/tb_ni_rx_dispatch.sv - directed and randomized bench for ni_rx_dispatch against a queue-based reference model
module tb_ni_rx_dispatch;
`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seq_err, par_err;
  logic [7:0]  err_cnt;
  logic [15:0] mem_cnt, logic_cnt;

  ni_rx_dispatch_if bus();

  ni_rx_dispatch #(.NumSrc(16), .ErrCntWidth(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SeqErr_o(seq_err), .ParErr_o(par_err), .ErrCnt_o(err_cnt),
    .MemPktCnt_o(mem_cnt), .LogicPktCnt_o(logic_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted flit is judged in arrival order; deliveries queue per channel.
  logic [27:0] mem_q[$];
  logic [27:0] logic_q[$];
  logic [1:0]  m_exp [16];
  int m_par, m_seq, obs_par, obs_seq, mem_hs, logic_hs;

  task automatic model_accept(input logic [31:0] f);
    logic [3:0] s;
    logic [1:0] q;
    if (^f) begin
      m_par++;
    end else begin
      s = f[31:28];
      q = f[26:25];
      if (q != m_exp[s]) m_seq++;
      m_exp[s] = q + 2'd1;
      if (f[27]) mem_q.push_back({s, f[23:0]});
      else       logic_q.push_back({s, f[23:0]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      logic_q.delete();
      for (int i = 0; i < 16; i++) m_exp[i] = 2'd0;
      m_par = 0; m_seq = 0; obs_par = 0; obs_seq = 0; mem_hs = 0; logic_hs = 0;
    end else begin
      if (bus.Valid_i && bus.Ready_o) model_accept(bus.Data_i);
      if (bus.MemValid_o && bus.MemReady_i) begin
        mem_hs++;
        if (mem_q.size() == 0) check("mem_unexpected", 1, 0);
        else check("mem_out", {bus.MemSrc_o, bus.MemData_o}, mem_q.pop_front());
      end
      if (bus.LogicValid_o && bus.LogicReady_i) begin
        logic_hs++;
        if (logic_q.size() == 0) check("logic_unexpected", 1, 0);
        else check("logic_out", {bus.LogicSrc_o, bus.LogicData_o}, logic_q.pop_front());
      end
      if (seq_err) obs_seq++;
      if (par_err) obs_par++;
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.MemReady_i   = ($urandom_range(0, 3) != 0);
      bus.LogicReady_i = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] make_flit(input logic [3:0] s, input logic c, input logic [1:0] q,
                                             input logic [23:0] p, input logic bad);
    logic [31:0] f;
    f = {s, c, q, 1'b0, p};
    f[24] = ^f;
    if (bad) f[0] = ~f[0];
    return f;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] f);
    int n;
    n = 0;
    bus.Valid_i = 1'b1;
    bus.Data_i  = f;
    @(negedge clk);
    while (!bus.Ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.Valid_i = 1'b0;
    bus.Data_i  = $urandom;
  endtask

  task automatic do_reset();
    bus.Valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    @(posedge clk); #2;
    bus.MemReady_i   = 1'b1;
    bus.LogicReady_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    int e;
    e = (m_par + m_seq > 255) ? 255 : m_par + m_seq;
    check({tag, "_memq_left"}, mem_q.size(), 0);
    check({tag, "_logicq_left"}, logic_q.size(), 0);
    check({tag, "_par_pulses"}, obs_par, m_par);
    check({tag, "_seq_pulses"}, obs_seq, m_seq);
    check({tag, "_errcnt"}, err_cnt, e);
    check({tag, "_mem_pkt"}, mem_cnt, STATS ? mem_hs[15:0] : 16'd0);
    check({tag, "_logic_pkt"}, logic_cnt, STATS ? logic_hs[15:0] : 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] p1;
    logic [31:0] mf;
    logic [3:0]  s;
    logic        c;
    logic [1:0]  q;
    int nm, nl;
    bus.Valid_i = 1'b0; bus.Data_i = 32'd0;
    bus.MemReady_i = 1'b1; bus.LogicReady_i = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.Ready_o, 0);
    check("rst_memvalid", bus.MemValid_o, 0);
    check("rst_logicvalid", bus.LogicValid_o, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_pulses", {seq_err, par_err}, 0);
    check("rst_pkt", {mem_cnt, logic_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_ready_lo", bus.Ready_o, 0);
    @(negedge clk);
    check("release_ready_hi", bus.Ready_o, 1);
    @(posedge clk); #1;

    // Basic memory delivery with one-edge latency
    send(32'h3800_00AB);
    @(negedge clk);
    check("t1_not_early", bus.MemValid_o, 0);
    @(negedge clk);
    check("t1_memvalid", bus.MemValid_o, 1);
    check("t1_memdata", bus.MemData_o, 24'h0000AB);
    check("t1_memsrc", bus.MemSrc_o, 3);
    check("t1_no_err", {seq_err, par_err}, 0);
    repeat (3) @(posedge clk); #1;

    // Parity drop
    send(make_flit(4'd3, 1'b1, 2'd1, 24'h0000AB, 1'b1));
    @(negedge clk);
    @(negedge clk);
    check("t2_parerr", par_err, 1);
    check("t2_errcnt", err_cnt, 1);
    check("t2_no_valid", {bus.MemValid_o, bus.LogicValid_o}, 0);
    check("t2_ready", bus.Ready_o, 1);
    @(negedge clk);
    check("t2_pulse_once", par_err, 0);
    @(posedge clk); #1;
    end_checks("t2");

    // Sequence mismatch and wrap
    do_reset();
    send(make_flit(4'd5, 1'b0, 2'd0, 24'h111111, 1'b0));
    send(make_flit(4'd5, 1'b0, 2'd1, 24'h222222, 1'b0));
    send(make_flit(4'd5, 1'b0, 2'd3, 24'h333333, 1'b0));
    repeat (4) @(posedge clk); #1;
    check("t3_seq_pulses", obs_seq, 1);
    check("t3_errcnt", err_cnt, 1);
    send(make_flit(4'd5, 1'b0, 2'd0, 24'h444444, 1'b0));
    repeat (4) @(posedge clk); #1;
    check("t3_wrap_no_err", obs_seq, 1);
    check("t3_delivered", logic_hs, 4);
    end_checks("t3");

    // Head-of-line blocking on the logic channel
    do_reset();
    bus.LogicReady_i = 1'b0;
    p1 = 24'($urandom);
    send(make_flit(4'd1, 1'b0, 2'd0, p1, 1'b0));
    send(make_flit(4'd1, 1'b0, 2'd1, 24'($urandom), 1'b0));
    send(make_flit(4'd1, 1'b0, 2'd2, 24'($urandom), 1'b0));
    mf = make_flit(4'd6, 1'b1, 2'd0, 24'($urandom), 1'b0);
    bus.Valid_i = 1'b1;
    bus.Data_i  = mf;
    repeat (3) begin
      @(negedge clk);
      check("t4_ready_lo", bus.Ready_o, 0);
      check("t4_hold_valid", bus.LogicValid_o, 1);
      check("t4_hold_data", bus.LogicData_o, p1);
      check("t4_mem_idle", bus.MemValid_o, 0);
    end
    @(posedge clk); #1;
    bus.LogicReady_i = 1'b1;
    bus.Valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_drain_rate", bus.LogicValid_o, 1);
    end
    @(posedge clk); #1;
    send(mf);
    drain();
    check("t4_logic_count", logic_hs, 3);
    end_checks("t4");

    // Reset with FIFO full and both channels loaded
    do_reset();
    bus.MemReady_i = 1'b0; bus.LogicReady_i = 1'b0;
    send(make_flit(4'd2, 1'b1, 2'd0, 24'($urandom), 1'b0));
    send(make_flit(4'd4, 1'b0, 2'd0, 24'($urandom), 1'b0));
    send(make_flit(4'd2, 1'b1, 2'd1, 24'($urandom), 1'b0));
    send(make_flit(4'd4, 1'b0, 2'd1, 24'($urandom), 1'b0));
    @(negedge clk);
    check("t5_full", {bus.Ready_o, bus.MemValid_o, bus.LogicValid_o}, 3'b011);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valids_clr", {bus.MemValid_o, bus.LogicValid_o}, 0);
    check("t5_errcnt", err_cnt, 0);
    check("t5_no_pulse", {seq_err, par_err}, 0);
    check("t5_ready_lo", bus.Ready_o, 0);
    @(negedge clk);
    check("t5_ready_hi", bus.Ready_o, 1);
    @(posedge clk); #1;
    bus.MemReady_i = 1'b1; bus.LogicReady_i = 1'b1;
    drain();
    end_checks("t5");

    // Error counter saturation
    do_reset();
    repeat (258) send(make_flit(4'($urandom), 1'($urandom), 2'($urandom), 24'($urandom), 1'b1));
    drain();
    check("sat_errcnt", err_cnt, 255);
    end_checks("sat");

    // Randomized traffic with random sink backpressure
    do_reset();
    rand_ready = 1'b1;
    repeat (400) begin
      s = 4'($urandom_range(0, 15));
      c = 1'($urandom_range(0, 1));
      q = ($urandom_range(0, 3) == 0) ? 2'($urandom) : m_exp[s];
      send(make_flit(s, c, q, 24'($urandom), $urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    end_checks("rand");

    // Delivery statistics: 10 memory and 6 logic payloads
    do_reset();
    nm = 0; nl = 0;
    while (nm < 10 || nl < 6) begin
      c = (nl >= 6) ? 1'b1 : (nm >= 10) ? 1'b0 : 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      send(make_flit(s, c, m_exp[s], 24'($urandom), 1'b0));
      if (c) nm++; else nl++;
    end
    drain();
    check("t6_mem_pkt", mem_cnt, STATS ? 16'd10 : 16'd0);
    check("t6_logic_pkt", logic_cnt, STATS ? 16'd6 : 16'd0);
    end_checks("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
